// File: rtl/decoder_scan_pkg.sv
// Shared types and helpers for the decoder_scan block: FSM state encoding,
// mode constants and a one-hot decode helper.
package decoder_pkg;

   typedef enum logic [1:0] {
      ST_OFF    = 2'd0,
      ST_DIRECT = 2'd1,
      ST_SCAN   = 2'd2
   } state_t;

   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

   // Callers zero-extend their select to ONEHOT_MAX_SEL_W and size-cast the
   // result down to their own 2**SEL_W outputs.
   localparam int unsigned ONEHOT_MAX_SEL_W = 8;
   localparam int unsigned ONEHOT_MAX_W     = 2 ** ONEHOT_MAX_SEL_W;

   function automatic logic [ONEHOT_MAX_W-1:0] onehot(
      input logic [ONEHOT_MAX_SEL_W-1:0] idx
   );
      logic [ONEHOT_MAX_W-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/decoder_scan_prescaler.sv
// Scan step prescaler: counts run cycles and emits a tick on the last cycle
// of each PRESCALE-long period; clear restarts the period.
module scan_prescaler #(
   parameter int unsigned PRESCALE   = 4,
   parameter int unsigned PRESCALE_W = $clog2(PRESCALE) + 1
) (
   input  logic clk,
   input  logic reset,
   input  logic run,
   input  logic clear,
   output logic tick
);

   logic [PRESCALE_W-1:0] r_count;
   logic                  w_at_end;

   assign w_at_end = (r_count == PRESCALE_W'(PRESCALE - 1));
   assign tick     = run && !clear && w_at_end;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         r_count <= '0;
      end else if (run) begin
         if (w_at_end) r_count <= '0;
         else          r_count <= r_count + 1'b1;
      end
   end

endmodule

// File: rtl/decoder_scan.sv
// Registered SEL_W-to-2**SEL_W decoder with DIRECT (loaded select) and SCAN
// (prescaled sweep) modes. Define DECODER_SCAN_ACTIVE_LOW_EN for one-cold output.
module decoder_scan
   import decoder_pkg::*;
#(
   parameter int unsigned SEL_W      = 3,
   parameter int unsigned PRESCALE   = 4,
   parameter int unsigned PRESCALE_W = $clog2(PRESCALE) + 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  mode,
   input  logic                  load,
   input  logic [SEL_W-1:0]      sel_in,
   input  logic [SEL_W-1:0]      last_idx,
   output logic [2**SEL_W-1:0]   out_onehot,
   output logic [SEL_W-1:0]      cur_idx,
   output logic                  step_pulse,
   output logic                  wrap
);

   localparam int unsigned N_OUT = 2 ** SEL_W;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [SEL_W-1:0]   r_idx;
   logic [SEL_W-1:0]   w_idx_nxt;
   logic [N_OUT-1:0]   r_dec;
   logic [N_OUT-1:0]   w_dec_nxt;
   logic               r_step;
   logic               w_step_nxt;
   logic               r_wrap;
   logic               w_wrap_nxt;
   logic               w_run;
   logic               w_clear;
   logic               w_tick;

   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_OFF;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = ST_OFF;
      if (enable) begin
         if (mode == MODE_SCAN) w_state_nxt = ST_SCAN;
         else                   w_state_nxt = ST_DIRECT;
      end
   end

   // Count only while staying in SCAN; entering SCAN or being in DIRECT
   // restarts the period, so a scan never resumes a stale count.
   assign w_run   = (r_state == ST_SCAN) && (w_state_nxt == ST_SCAN);
   assign w_clear = (w_state_nxt == ST_DIRECT) ||
                    ((w_state_nxt == ST_SCAN) && (r_state != ST_SCAN));

   scan_prescaler #(
      .PRESCALE   (PRESCALE),
      .PRESCALE_W (PRESCALE_W)
   ) u_prescaler (
      .clk   (clk),
      .reset (reset),
      .run   (w_run),
      .clear (w_clear),
      .tick  (w_tick)
   );

   always_comb begin
      w_idx_nxt  = r_idx;
      w_dec_nxt  = '0;
      w_step_nxt = 1'b0;
      w_wrap_nxt = 1'b0;
      unique case (w_state_nxt)
         ST_DIRECT: begin
            if (load) w_idx_nxt = sel_in;
            w_dec_nxt = N_OUT'(onehot(ONEHOT_MAX_SEL_W'(w_idx_nxt)));
         end
         ST_SCAN: begin
            if (w_tick) begin
               w_step_nxt = 1'b1;
               if (r_idx >= last_idx) begin
                  w_idx_nxt  = '0;
                  w_wrap_nxt = 1'b1;
               end else begin
                  w_idx_nxt = r_idx + 1'b1;
               end
            end
            w_dec_nxt = N_OUT'(onehot(ONEHOT_MAX_SEL_W'(w_idx_nxt)));
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_idx  <= '0;
         r_dec  <= '0;
         r_step <= 1'b0;
         r_wrap <= 1'b0;
      end else begin
         r_idx  <= w_idx_nxt;
         r_dec  <= w_dec_nxt;
         r_step <= w_step_nxt;
         r_wrap <= w_wrap_nxt;
      end
   end

`ifdef DECODER_SCAN_ACTIVE_LOW_EN
   assign out_onehot = ~r_dec;
`else
   assign out_onehot = r_dec;
`endif
   assign cur_idx    = r_idx;
   assign step_pulse = r_step;
   assign wrap       = r_wrap;

endmodule

// File: tb/tb_decoder_scan.sv
// Directed self-checking bench for decoder_scan (SEL_W=3, PRESCALE=4).
module tb_decoder_scan;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic       mode;
   logic       load;
   logic [2:0] sel_in;
   logic [2:0] last_idx;
   logic [7:0] out_onehot;
   logic [2:0] cur_idx;
   logic       step_pulse;
   logic       wrap;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   decoder_scan #(
      .SEL_W    (3),
      .PRESCALE (4)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .mode       (mode),
      .load       (load),
      .sel_in     (sel_in),
      .last_idx   (last_idx),
      .out_onehot (out_onehot),
      .cur_idx    (cur_idx),
      .step_pulse (step_pulse),
      .wrap       (wrap)
   );

   function automatic logic [7:0] pol(input logic [7:0] v);
`ifdef DECODER_SCAN_ACTIVE_LOW_EN
      return ~v;
`else
      return v;
`endif
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_all(input string tag, input int idx, input logic sp,
                             input logic wr, input logic off);
      logic [7:0] oh;
      oh = off ? 8'h00 : (8'h01 << idx);
      check({tag, ".idx"},  32'(cur_idx),    32'(idx));
      check({tag, ".oh"},   32'(out_onehot), 32'(pol(oh)));
      check({tag, ".step"}, 32'(step_pulse), 32'(sp));
      check({tag, ".wrap"}, 32'(wrap),       32'(wr));
   endtask

   initial begin
      int steps;
      int wraps;

      reset = 1'b1; enable = 1'b0; mode = 1'b0; load = 1'b0;
      sel_in = 3'd0; last_idx = 3'd7;
      cyc(2);
      expect_all("reset", 0, 1'b0, 1'b0, 1'b1);

      reset = 1'b0; enable = 1'b1; mode = 1'b0; sel_in = 3'b110; load = 1'b1;
      cyc(1);
      expect_all("direct_load6", 6, 1'b0, 1'b0, 1'b0);
      check("direct_load6.pattern", 32'(out_onehot), 32'(pol(8'b0100_0000)));
      load = 1'b0; sel_in = 3'd2;
      cyc(1);
      expect_all("direct_hold", 6, 1'b0, 1'b0, 1'b0);
      enable = 1'b0;
      cyc(1);
      expect_all("off_hold", 6, 1'b0, 1'b0, 1'b1);
      load = 1'b1; sel_in = 3'd3;
      cyc(1);
      expect_all("off_load_ignored", 6, 1'b0, 1'b0, 1'b1);

      enable = 1'b1; mode = 1'b0; sel_in = 3'd0; load = 1'b1;
      cyc(1);
      expect_all("direct_load0", 0, 1'b0, 1'b0, 1'b0);
      load = 1'b0;

      // Full sweep: step every 4 cycles, one wrap on 7 -> 0.
      mode = 1'b1; last_idx = 3'd7;
      cyc(1);
      expect_all("scan_entry", 0, 1'b0, 1'b0, 1'b0);
      steps = 0; wraps = 0;
      for (int c = 1; c <= 32; c++) begin
         cyc(1);
         expect_all("sweep", (c / 4) % 8, (c % 4) == 0, c == 32, 1'b0);
         steps += int'(step_pulse);
         wraps += int'(wrap);
      end
      check("sweep_step_count", 32'(steps), 32'd8);
      check("sweep_wrap_count", 32'(wraps), 32'd1);

      // Sub-range entered with retained index above last_idx.
      mode = 1'b0; load = 1'b1; sel_in = 3'd6;
      cyc(1);
      expect_all("direct_load6b", 6, 1'b0, 1'b0, 1'b0);
      load = 1'b0; mode = 1'b1; last_idx = 3'd3;
      cyc(1);
      expect_all("sub_entry", 6, 1'b0, 1'b0, 1'b0);
      cyc(3);
      expect_all("sub_pre", 6, 1'b0, 1'b0, 1'b0);
      cyc(1);
      expect_all("sub_first_wrap", 0, 1'b1, 1'b1, 1'b0);
      for (int k = 1; k <= 4; k++) begin
         cyc(3);
         expect_all("sub_mid", k - 1, 1'b0, 1'b0, 1'b0);
         cyc(1);
         expect_all("sub_step", k % 4, 1'b1, k == 4, 1'b0);
      end

      // Freeze: partial count is discarded across an OFF period.
      cyc(4);
      expect_all("frz_step", 1, 1'b1, 1'b0, 1'b0);
      cyc(2);
      expect_all("frz_mid", 1, 1'b0, 1'b0, 1'b0);
      enable = 1'b0;
      cyc(1);
      expect_all("frz_off", 1, 1'b0, 1'b0, 1'b1);
      cyc(9);
      expect_all("frz_off10", 1, 1'b0, 1'b0, 1'b1);
      enable = 1'b1;
      cyc(1);
      expect_all("frz_reentry", 1, 1'b0, 1'b0, 1'b0);
      cyc(3);
      expect_all("frz_pre", 1, 1'b0, 1'b0, 1'b0);
      cyc(1);
      expect_all("frz_step2", 2, 1'b1, 1'b0, 1'b0);

      // last_idx = 0 takes effect at the next step; load ignored in SCAN.
      last_idx = 3'd0; load = 1'b1; sel_in = 3'd7;
      cyc(3);
      expect_all("last0_pre", 2, 1'b0, 1'b0, 1'b0);
      cyc(1);
      expect_all("last0_wrap", 0, 1'b1, 1'b1, 1'b0);
      cyc(3);
      expect_all("last0_hold", 0, 1'b0, 1'b0, 1'b0);
      cyc(1);
      expect_all("last0_wrap2", 0, 1'b1, 1'b1, 1'b0);
      load = 1'b0;

      // Reset on what would otherwise be a step edge.
      mode = 1'b0; load = 1'b1; sel_in = 3'd5;
      cyc(1);
      expect_all("direct_load5", 5, 1'b0, 1'b0, 1'b0);
      load = 1'b0; mode = 1'b1; last_idx = 3'd7;
      cyc(1);
      expect_all("scan5_entry", 5, 1'b0, 1'b0, 1'b0);
      cyc(3);
      expect_all("scan5_pre", 5, 1'b0, 1'b0, 1'b0);
      reset = 1'b1;
      cyc(1);
      expect_all("reset_midscan", 0, 1'b0, 1'b0, 1'b1);
      reset = 1'b0;
      cyc(1);
      expect_all("post_reset_entry", 0, 1'b0, 1'b0, 1'b0);
      cyc(3);
      expect_all("post_reset_pre", 0, 1'b0, 1'b0, 1'b0);
      cyc(1);
      expect_all("post_reset_step", 1, 1'b1, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
